glitch_sequencer: RTL and testbench
===================================

Name: glitch_sequencer

Overview:
- Programmable, trigger-aligned glitch scheduler. It drives the select/enable for the downstream clock glitch mux.
- When armed and triggered, it waits a configurable delay, then issues a configurable number of glitch windows of set width and spacing.
- For each window it also chooses which of NUM_SRC glitch clock sources is routed.
- It sits between the control/UART register block and the glitch clock mux, and runs entirely in the clk_in1 domain.

Parameters:
- CNT_W, 16, width of delay/width/gap counters and config fields
- REP_W, 8, width of repeat count and pulses_issued
- NUM_SRC, 4, number of selectable glitch clock sources (>=2)
- SRC_W, $clog2(NUM_SRC), derived, width of source select

Ports:
- clk_in1  input  1  system clock; all logic on rising edge
- resetn  input  1  asynchronous active-low reset
- arm  input  1  level; sampled in IDLE, latches all cfg_* fields
- trigger  input  1  synchronous target trigger; rising edge detected internally
- abort  input  1  synchronous; cancels any sequence
- cfg_delay  input  CNT_W  cycles from trigger edge to first glitch
- cfg_width  input  CNT_W  glitch window length in cycles (0 treated as 1)
- cfg_gap  input  CNT_W  cycles between windows (0 treated as 1)
- cfg_repeat  input  REP_W  number of windows (0 treated as 1)
- cfg_src  input  SRC_W  starting source index
- cfg_rotate  input  1  1 = advance source index after each window, modulo NUM_SRC
- glitch_en  output  1  registered; high during a glitch window; feeds the mux select
- glitch_src  output  SRC_W  registered source index; valid while glitch_en=1
- busy  output  1  high in ARMED/DELAY/GLITCH/GAP
- done  output  1  one-cycle pulse when the sequence completes normally
- pulses_issued  output  REP_W  windows completed in the current or last sequence

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE; all outputs 0; trigger edge register cleared.
- States are IDLE, ARMED, DELAY, GLITCH, GAP.
- IDLE:
  - arm=1 latches cfg_*, clears pulses_issued, and moves to ARMED next cycle.
  - A latched value of 0 in width, gap or repeat is stored as 1.
- ARMED:
  - A trigger rising edge (trigger=1 now, 0 the previous cycle) moves to DELAY, or to GLITCH directly if delay=0.
  - A trigger held high while arming is not an edge.
- Latency:
  - Edge sampled at cycle T means glitch_en first high at T+1+delay.
  - Each window is exactly width cycles high.
  - Windows are separated by exactly gap cycles low.
- GLITCH:
  - glitch_en=1 and glitch_src=current index.
  - On the last cycle of the window, pulses_issued increments (saturating at 2^REP_W-1).
  - If pulses_issued has reached repeat, go to IDLE; otherwise go to GAP.
- GAP:
  - glitch_en=0.
  - After gap cycles, go to GLITCH.
  - If cfg_rotate=1, the source index advances by 1 before the next window and wraps NUM_SRC-1 -> 0.
- Completion:
  - done pulses for one cycle, coinciding with the first cycle glitch_en=0 after the final window.
  - busy drops the same cycle.
- glitch_src:
  - Holds its value when glitch_en=0.
  - Only changes on a GAP->GLITCH transition or at arm.
- abort:
  - From any state, the next state is IDLE; glitch_en=0 and busy=0 next cycle; no done pulse.
  - pulses_issued keeps its value.
  - abort has priority over arm, trigger and counter expiry.
- Ignored inputs:
  - arm and cfg_* changes outside IDLE are ignored.
  - Trigger edges outside ARMED are ignored; there is no queuing.
- Width and arithmetic:
  - Counters are CNT_W wide and count down from the latched value; they never wrap.
  - Maximum delay is 2^CNT_W-1 cycles.
- Output timing: glitch_en is driven from a flop, never combinationally from trigger, so the mux select is glitch-free.

Test Plan:
- Reset/idle: resetn low mid-GLITCH with width=10 -> glitch_en, busy, done, pulses_issued all 0 immediately (asynchronous); state IDLE after release.
- Basic: delay=5, width=3, gap=2, repeat=1, src=2, arm, then trigger edge at T -> glitch_en high T+6..T+8 with glitch_src=2; done at T+9; pulses_issued=1.
- Zero fields: delay=0, width=0, gap=0, repeat=0, edge at T -> single 1-cycle glitch at T+1; done at T+2.
- Rotate wrap: NUM_SRC=4, src=3, rotate=1, repeat=3, width=2, gap=4 -> windows with glitch_src 3, 0, 1; 4-cycle gaps; pulses_issued=3.
- Abort: repeat=5, abort asserted during the 2nd window -> glitch_en low next cycle, no done, pulses_issued=1, busy=0; a following trigger edge produces nothing.
- Ignored inputs: trigger held high through arm gives no start; re-arm while busy and a second trigger during DELAY -> timing unchanged, only one sequence runs.

Source files
------------

// File: rtl/glitch_sequencer.sv
// glitch_sequencer
//   Trigger-aligned glitch scheduler. Once armed, a rising edge on trigger
//   starts a countdown of cfg_delay cycles. After that it issues cfg_repeat
//   glitch windows, each cfg_width cycles long, separated by cfg_gap idle
//   cycles. For every window it selects one of NUM_SRC glitch clock sources,
//   optionally rotating through them.
//
// Ports
//   clk_in1       system clock, rising edge
//   resetn        asynchronous active-low reset
//   arm           level; in IDLE latches all cfg_* fields
//   trigger       target trigger; a rising edge is only honoured in ARMED
//   abort         synchronous cancel from any state, highest priority
//   cfg_delay     cycles from trigger edge to first window
//   cfg_width     window length (0 -> 1)
//   cfg_gap       cycles between windows (0 -> 1)
//   cfg_repeat    number of windows (0 -> 1)
//   cfg_src       starting source index
//   cfg_rotate    advance source index after each window, modulo NUM_SRC
//   glitch_en     registered mux enable, high during a window
//   glitch_src    registered source index, stable while glitch_en is high
//   busy          high in ARMED/DELAY/GLITCH/GAP
//   done          one-cycle pulse on normal completion
//   pulses_issued windows completed in the current or last sequence
module glitch_sequencer #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned REP_W   = 8,
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned SRC_W   = $clog2(NUM_SRC)
) (
  input  logic             clk_in1,
  input  logic             resetn,
  input  logic             arm,
  input  logic             trigger,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_gap,
  input  logic [REP_W-1:0] cfg_repeat,
  input  logic [SRC_W-1:0] cfg_src,
  input  logic             cfg_rotate,
  output logic             glitch_en,
  output logic [SRC_W-1:0] glitch_src,
  output logic             busy,
  output logic             done,
  output logic [REP_W-1:0] pulses_issued
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DELAY,
    S_GLITCH,
    S_GAP
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   delay_q, delay_d;
  logic [CNT_W-1:0]   width_q, width_d;
  logic [CNT_W-1:0]   gap_q, gap_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic               rot_q, rot_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic [REP_W-1:0]   pulses_q, pulses_d;
  logic               trig_q;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               trig_edge;
  logic               cnt_last;
  logic [REP_W-1:0]   pulses_inc;
  logic [SRC_W-1:0]   src_next;

  assign trig_edge  = trigger & ~trig_q;
  assign cnt_last   = (cnt_q <= CNT_W'(1));
  assign pulses_inc = (pulses_q == '1) ? pulses_q : pulses_q + REP_W'(1);
  assign src_next   = (src_q == SRC_W'(NUM_SRC - 1)) ? '0 : src_q + SRC_W'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    delay_d  = delay_q;
    width_d  = width_q;
    gap_d    = gap_q;
    rep_d    = rep_q;
    rot_d    = rot_q;
    src_d    = src_q;
    pulses_d = pulses_q;
    done_d   = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            delay_d  = cfg_delay;
            width_d  = (cfg_width  == '0) ? CNT_W'(1) : cfg_width;
            gap_d    = (cfg_gap    == '0) ? CNT_W'(1) : cfg_gap;
            rep_d    = (cfg_repeat == '0) ? REP_W'(1) : cfg_repeat;
            rot_d    = cfg_rotate;
            src_d    = cfg_src;
            pulses_d = '0;
            state_d  = S_ARMED;
          end
        end
        S_ARMED: begin
          if (trig_edge) begin
            if (delay_q == '0) begin
              state_d = S_GLITCH;
              cnt_d   = width_q;
            end else begin
              state_d = S_DELAY;
              cnt_d   = delay_q;
            end
          end
        end
        S_DELAY: begin
          if (cnt_last) begin
            state_d = S_GLITCH;
            cnt_d   = width_q;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_GLITCH: begin
          if (cnt_last) begin
            pulses_d = pulses_inc;
            if (pulses_inc >= rep_q) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_GAP;
              cnt_d   = gap_q;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_GAP: begin
          if (cnt_last) begin
            state_d = S_GLITCH;
            cnt_d   = width_q;
            if (rot_q) begin
              src_d = src_next;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are registered copies of the next state so the mux select
    // never depends combinationally on trigger.
    en_d   = (state_d == S_GLITCH);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_in1 or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      delay_q  <= '0;
      width_q  <= '0;
      gap_q    <= '0;
      rep_q    <= '0;
      rot_q    <= 1'b0;
      src_q    <= '0;
      pulses_q <= '0;
      trig_q   <= 1'b0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      delay_q  <= delay_d;
      width_q  <= width_d;
      gap_q    <= gap_d;
      rep_q    <= rep_d;
      rot_q    <= rot_d;
      src_q    <= src_d;
      pulses_q <= pulses_d;
      trig_q   <= trigger;
      en_q     <= en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign glitch_en     = en_q;
  assign glitch_src    = src_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pulses_issued = pulses_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
module tb_glitch_sequencer;

  localparam int CNT_W   = 16;
  localparam int REP_W   = 8;
  localparam int NUM_SRC = 4;
  localparam int SRC_W   = 2;

  logic             clk_in1;
  logic             resetn;
  logic             arm;
  logic             trigger;
  logic             abort;
  logic [CNT_W-1:0] cfg_delay;
  logic [CNT_W-1:0] cfg_width;
  logic [CNT_W-1:0] cfg_gap;
  logic [REP_W-1:0] cfg_repeat;
  logic [SRC_W-1:0] cfg_src;
  logic             cfg_rotate;
  logic             glitch_en;
  logic [SRC_W-1:0] glitch_src;
  logic             busy;
  logic             done;
  logic [REP_W-1:0] pulses_issued;

  glitch_sequencer #(
    .CNT_W  (CNT_W),
    .REP_W  (REP_W),
    .NUM_SRC(NUM_SRC)
  ) dut (
    .clk_in1      (clk_in1),
    .resetn       (resetn),
    .arm          (arm),
    .trigger      (trigger),
    .abort        (abort),
    .cfg_delay    (cfg_delay),
    .cfg_width    (cfg_width),
    .cfg_gap      (cfg_gap),
    .cfg_repeat   (cfg_repeat),
    .cfg_src      (cfg_src),
    .cfg_rotate   (cfg_rotate),
    .glitch_en    (glitch_en),
    .glitch_src   (glitch_src),
    .busy         (busy),
    .done         (done),
    .pulses_issued(pulses_issued)
  );

  initial clk_in1 = 1'b0;
  always #5 clk_in1 = ~clk_in1;

  typedef struct packed {
    logic             en;
    logic             busy;
    logic             done;
    logic [SRC_W-1:0] src;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic en, input logic bz, input logic dn, input int src);
    exp_t r;
    r.en   = en;
    r.busy = bz;
    r.done = dn;
    r.src  = SRC_W'(src);
    return r;
  endfunction

  // Expected per-cycle trace starting the cycle after the trigger edge.
  task automatic plan(input int d, input int w, input int g, input int r, input int s, input int rot);
    int wi, gi, ri, sc;
    wi = (w == 0) ? 1 : w;
    gi = (g == 0) ? 1 : g;
    ri = (r == 0) ? 1 : r;
    sc = s;
    for (int i = 0; i < d; i++) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, sc));
    for (int k = 0; k < ri; k++) begin
      for (int i = 0; i < wi; i++) exp_q.push_back(mk(1'b1, 1'b1, 1'b0, sc));
      if (k < ri - 1) begin
        for (int i = 0; i < gi; i++) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, sc));
        if (rot != 0) sc = (sc + 1) % NUM_SRC;
      end
    end
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, sc));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, sc));
  endtask

  task automatic do_arm(input int d, input int w, input int g, input int r, input int s, input int rot);
    @(posedge clk_in1); #1;
    cfg_delay  = CNT_W'(d);
    cfg_width  = CNT_W'(w);
    cfg_gap    = CNT_W'(g);
    cfg_repeat = REP_W'(r);
    cfg_src    = SRC_W'(s);
    cfg_rotate = (rot != 0);
    arm        = 1'b1;
    @(posedge clk_in1); #1;
    arm = 1'b0;
    @(negedge clk_in1);
    check_val("armed_busy", busy, 1);
    check_val("armed_en", glitch_en, 0);
    check_val("armed_pulses", pulses_issued, 0);
    check_val("armed_src", glitch_src, s);
  endtask

  task automatic start(input int d, input int w, input int g, input int r, input int s, input int rot);
    do_arm(d, w, g, r, s, rot);
    @(posedge clk_in1); #1;
    trigger = 1'b1;
    plan(d, w, g, r, s, rot);
  endtask

  // Pops one expectation per cycle; abort/arm/trigger can be pulsed at a
  // given cycle index. An abort replaces the remaining trace with idle.
  task automatic run_seq(input int abort_at, input int rearm_at, input int trig_at);
    exp_t e;
    int   c;
    c = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk_in1); #1;
      trigger = (c == trig_at);
      arm     = (c == rearm_at);
      abort   = (c == abort_at);
      @(negedge clk_in1);
      e = exp_q.pop_front();
      check_val("glitch_en", glitch_en, e.en);
      check_val("busy", busy, e.busy);
      check_val("done", done, e.done);
      check_val("glitch_src", glitch_src, e.src);
      if (abort) begin
        exp_q.delete();
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, e.src));
      end
      c++;
    end
    @(posedge clk_in1); #1;
    trigger = 1'b0;
    arm     = 1'b0;
    abort   = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in1); #1;
      @(negedge clk_in1);
      check_val("idle_en", glitch_en, 0);
      check_val("idle_busy", busy, 0);
      check_val("idle_done", done, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn     = 1'b0;
    arm        = 1'b0;
    trigger    = 1'b0;
    abort      = 1'b0;
    cfg_delay  = '0;
    cfg_width  = '0;
    cfg_gap    = '0;
    cfg_repeat = '0;
    cfg_src    = '0;
    cfg_rotate = 1'b0;
    repeat (3) @(posedge clk_in1);
    @(negedge clk_in1);
    check_val("rst_en", glitch_en, 0);
    check_val("rst_src", glitch_src, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_pulses", pulses_issued, 0);
    resetn = 1'b1;
    idle_cycles(2);

    // Basic single window.
    start(5, 3, 2, 1, 2, 0);
    run_seq(-1, -1, -1);
    check_val("basic_pulses", pulses_issued, 1);

    // All-zero fields collapse to a single one-cycle window.
    start(0, 0, 0, 0, 1, 0);
    run_seq(-1, -1, -1);
    check_val("zero_pulses", pulses_issued, 1);

    // Source rotation wrapping 3 -> 0 -> 1.
    start(1, 2, 4, 3, 3, 1);
    run_seq(-1, -1, -1);
    check_val("rot_pulses", pulses_issued, 3);

    // Abort during the second window; a later edge starts nothing.
    start(2, 3, 2, 5, 0, 1);
    run_seq(8, -1, -1);
    check_val("abort_pulses", pulses_issued, 1);
    @(posedge clk_in1); #1;
    trigger = 1'b1;
    @(posedge clk_in1); #1;
    trigger = 1'b0;
    idle_cycles(4);
    check_val("abort_pulses_hold", pulses_issued, 1);

    // Trigger held high through arming is not an edge.
    @(posedge clk_in1); #1;
    trigger = 1'b1;
    do_arm(0, 2, 1, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_in1); #1;
      @(negedge clk_in1);
      check_val("held_en", glitch_en, 0);
      check_val("held_busy", busy, 1);
    end
    @(posedge clk_in1); #1;
    trigger = 1'b0;
    @(posedge clk_in1); #1;
    trigger = 1'b1;
    plan(0, 2, 1, 1, 1, 0);
    run_seq(-1, -1, -1);
    check_val("held_pulses", pulses_issued, 1);

    // Re-arm, config changes and a second trigger while busy are ignored.
    start(6, 2, 3, 2, 2, 0);
    cfg_delay  = CNT_W'(1);
    cfg_width  = CNT_W'(7);
    cfg_gap    = CNT_W'(1);
    cfg_repeat = REP_W'(4);
    cfg_src    = SRC_W'(0);
    cfg_rotate = 1'b1;
    run_seq(-1, 1, 2);
    check_val("ign_pulses", pulses_issued, 2);
    idle_cycles(3);

    // Asynchronous reset in the middle of the second window.
    do_arm(0, 10, 1, 2, 3, 0);
    @(posedge clk_in1); #1;
    trigger = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk_in1); #1;
      trigger = 1'b0;
    end
    @(negedge clk_in1);
    check_val("pre_rst_en", glitch_en, 1);
    check_val("pre_rst_pulses", pulses_issued, 1);
    #2;
    resetn = 1'b0;
    #1;
    check_val("arst_en", glitch_en, 0);
    check_val("arst_busy", busy, 0);
    check_val("arst_done", done, 0);
    check_val("arst_pulses", pulses_issued, 0);
    check_val("arst_src", glitch_src, 0);
    @(negedge clk_in1);
    resetn = 1'b1;
    idle_cycles(3);
    start(0, 1, 1, 1, 0, 0);
    run_seq(-1, -1, -1);
    check_val("post_rst_pulses", pulses_issued, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
